// File: rtl/decoder_low_pkg.sv
// ---------------------------------------------------------------------------
// Module  : decoder_low_pkg
// Brief   : Shared FSM state encoding and parameter range limits for the
//           registered active-low decoder.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package decoder_low_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam int c_dead_cyc_min = 0;
  localparam int c_dead_cyc_max = 15;
  localparam int c_scan_div_min = 1;
  localparam int c_scan_div_max = 255;

  function automatic int clamp(input int val, input int lo, input int hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_low_enc.sv
// ---------------------------------------------------------------------------
// Module  : onehot_low_enc
// Brief   : Combinational index to active-low one-hot encoder; all-high when
//           en is low.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module onehot_low_enc #(
  parameter int SEL_W = 2
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        idx,
  output logic [(2**SEL_W)-1:0]   code_n
);

  always_comb begin
    code_n = '1;
    if (en) begin
      code_n[idx] = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/registered_decoder_low.sv
// ---------------------------------------------------------------------------
// Module  : registered_decoder_low
// Brief   : Registered active-low decoder with break-before-make dead time.
//           Optional auto-scan enabled by defining DECODER_LOW_SCAN_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module registered_decoder_low
  import decoder_low_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int DEAD_CYC = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  scan,
  output logic [(2**SEL_W)-1:0] d_n,
  output logic [SEL_W-1:0]      active_idx,
  output logic                  busy
);

  localparam int         c_dead_cyc  = clamp(DEAD_CYC, c_dead_cyc_min, c_dead_cyc_max);
  localparam int         c_scan_div  = clamp(SCAN_DIV, c_scan_div_min, c_scan_div_max);
  localparam logic [3:0] c_dead_load = (c_dead_cyc == 0) ? 4'd0 : 4'(c_dead_cyc - 1);

  state_t                  r_state;
  logic [SEL_W-1:0]        r_cur;
  logic [SEL_W-1:0]        r_pend;
  logic [3:0]              r_dead_cnt;
  logic                    w_step;
  logic [SEL_W-1:0]        w_step_idx;
  logic                    w_drive_en;
  logic [(2**SEL_W)-1:0]   w_code_n;

  assign w_step_idx = r_cur + SEL_W'(1);

`ifdef DECODER_LOW_SCAN_EN
  logic [7:0] r_scan_div;

  assign w_step = (r_state == DRIVE) && scan && (r_scan_div == 8'(c_scan_div - 1));

  // Divider only runs while a code is held under scan; any load restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_div <= 8'd0;
    end else if (!en || (r_state != DRIVE) || !scan || load || w_step) begin
      r_scan_div <= 8'd0;
    end else begin
      r_scan_div <= r_scan_div + 8'd1;
    end
  end
`else
  logic w_unused_scan;

  assign w_unused_scan = scan;
  assign w_step        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_pend     <= '0;
      r_dead_cnt <= 4'd0;
    end else if (!en) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_pend     <= '0;
      r_dead_cnt <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_pend     <= sel;
            r_dead_cnt <= c_dead_load;
            if (c_dead_cyc == 0) begin
              r_cur   <= sel;
              r_state <= DRIVE;
            end else begin
              r_state <= DEAD;
            end
          end
        end
        DEAD: begin
          if (load) begin
            r_pend     <= sel;
            r_dead_cnt <= c_dead_load;
          end else if (r_dead_cnt == 4'd0) begin
            r_cur   <= r_pend;
            r_state <= DRIVE;
          end else begin
            r_dead_cnt <= r_dead_cnt - 4'd1;
          end
        end
        DRIVE: begin
          // A load always wins over a coincident scan step.
          if ((load && (sel != r_cur)) || (!load && w_step)) begin
            r_pend     <= load ? sel : w_step_idx;
            r_dead_cnt <= c_dead_load;
            if (c_dead_cyc == 0) begin
              r_cur <= load ? sel : w_step_idx;
            end else begin
              r_state <= DEAD;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // en gates the encoder so dropping en releases the output at the next edge.
  assign w_drive_en = en && (r_state == DRIVE);

  onehot_low_enc #(
    .SEL_W (SEL_W)
  ) u_enc (
    .en     (w_drive_en),
    .idx    (r_cur),
    .code_n (w_code_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_n        <= '1;
      active_idx <= '0;
      busy       <= 1'b0;
    end else begin
      d_n        <= w_code_n;
      active_idx <= w_drive_en ? r_cur : '0;
      busy       <= en && (r_state == DEAD);
    end
  end

endmodule

`default_nettype wire
